// File: rtl/fft_pkg.sv
// Shared constants and state type for the FFT sample loader and its helpers.
package fft_pkg;

    localparam int          DATA_W_DEF  = 16;
    localparam int          LOG2_N_DEF  = 5;
    localparam logic [15:0] PAT_AMP_DEF = 16'h03FF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } load_state_e;

endpackage

// File: rtl/fft_addr_bitrev.sv
// Combinational bit-order reversal of an index; shared by the FFT loader and unloader.
module fft_addr_bitrev #(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] idx_i,
    output logic [ADDR_W-1:0] rev_o
);

    always_comb begin
        rev_o = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            rev_o[i] = idx_i[ADDR_W-1-i];
        end
    end

endmodule

// File: rtl/fft_sample_loader.sv
// Loads N complex samples into FFT RAM at bit-reversed addresses (DIT input order).
// Optional square-wave bring-up source enabled by FFT_LOADER_PATTERN_GEN_EN.
module fft_sample_loader
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LOG2_N = LOG2_N_DEF
`ifdef FFT_LOADER_PATTERN_GEN_EN
    ,
    parameter logic [DATA_W-1:0] PAT_AMP = DATA_W'(PAT_AMP_DEF)
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              wr_en,
    output logic [LOG2_N-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_real,
    output logic [DATA_W-1:0] wr_imag,
    output logic              busy,
    output logic              done,
    input  logic              done_ack
`ifdef FFT_LOADER_PATTERN_GEN_EN
    ,
    input  logic              pat_mode
`endif
);

    localparam logic [LOG2_N-1:0] LAST_IDX = '1;

    load_state_e              state_q, state_d;
    logic        [LOG2_N-1:0] cnt_q, cnt_d;
    logic                     wr_en_q, wr_en_d;
    logic        [LOG2_N-1:0] wr_addr_q, wr_addr_d;
    logic signed [DATA_W-1:0] wr_real_q, wr_real_d;
    logic signed [DATA_W-1:0] wr_imag_q, wr_imag_d;

    logic                     accept;
    logic        [LOG2_N-1:0] rev_addr;
    logic signed [DATA_W-1:0] src_real, src_imag;

    fft_addr_bitrev #(
        .ADDR_W (LOG2_N)
    ) u_bitrev (
        .idx_i (cnt_q),
        .rev_o (rev_addr)
    );

`ifdef FFT_LOADER_PATTERN_GEN_EN
    logic                     pat_q;
    logic signed [DATA_W-1:0] pat_real;

    // Source select is latched when a frame starts and frozen until the next start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q <= 1'b0;
        end else if (start && (state_q != LOAD)) begin
            pat_q <= pat_mode;
        end
    end

    assign pat_real = cnt_q[LOG2_N-1] ? -$signed(PAT_AMP) : $signed(PAT_AMP);
    assign in_ready = (state_q == LOAD) && !pat_q;
    assign accept   = (state_q == LOAD) && (pat_q || in_valid);
    assign src_real = pat_q ? pat_real : $signed(in_real);
    assign src_imag = pat_q ? '0 : $signed(in_imag);
`else
    assign in_ready = (state_q == LOAD);
    assign accept   = in_ready && in_valid;
    assign src_real = $signed(in_real);
    assign src_imag = $signed(in_imag);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_real_d = wr_real_q;
        wr_imag_d = wr_imag_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = rev_addr;
                    wr_real_d = src_real;
                    wr_imag_d = src_imag;
                    // Counter parks at N-1 on the final sample so it never wraps.
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else if (done_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_real_q <= '0;
            wr_imag_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_real_q <= wr_real_d;
            wr_imag_q <= wr_imag_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_real = wr_real_q;
    assign wr_imag = wr_imag_q;
    assign busy    = (state_q == LOAD);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench for fft_sample_loader at LOG2_N=3 with a behavioural frame model.
module tb_fft_sample_loader;

    localparam int DW = 16;
    localparam int LN = 3;
    localparam int N  = 1 << LN;
    localparam logic [DW-1:0] AMP = 16'h03FF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          done_ack = 1'b0;
    logic [DW-1:0] in_real = '0;
    logic [DW-1:0] in_imag = '0;
    logic          in_ready, wr_en, busy, done;
    logic [LN-1:0] wr_addr;
    logic [DW-1:0] wr_real, wr_imag;
`ifdef FFT_LOADER_PATTERN_GEN_EN
    logic          pat_mode = 1'b0;
`endif

    typedef struct {
        int            addr;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            m_idx = 0;
    bit            m_active = 1'b0;
    int            last_addr = 0;
    logic [DW-1:0] last_re = '0;
    logic [DW-1:0] last_im = '0;

    fft_sample_loader #(
        .DATA_W (DW),
        .LOG2_N (LN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_real  (in_real),
        .in_imag  (in_imag),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_real  (wr_real),
        .wr_imag  (wr_imag),
        .busy     (busy),
        .done     (done),
        .done_ack (done_ack)
`ifdef FFT_LOADER_PATTERN_GEN_EN
        ,
        .pat_mode (pat_mode)
`endif
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Index reversal done arithmetically: peel low digits, push them in as high digits.
    function automatic int brev(input int v);
        int r = 0;
        for (int i = 0; i < LN; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // Monitor: every write must match the oldest expectation; idle cycles must hold outputs.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write actual=addr %0d required=no write", wr_addr);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                    chk("wr_real", 32'(wr_real), 32'(mon_e.re));
                    chk("wr_imag", 32'(wr_imag), 32'(mon_e.im));
                    chk("wr_latency", 32'(cyc), 32'(mon_e.cyc));
                    last_addr = mon_e.addr;
                    last_re   = mon_e.re;
                    last_im   = mon_e.im;
                end
            end else begin
                chk("hold_addr", 32'(wr_addr), 32'(last_addr));
                chk("hold_real", 32'(wr_real), 32'(last_re));
                chk("hold_imag", 32'(wr_imag), 32'(last_im));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit with_ack);
        start    = 1'b1;
        done_ack = with_ack;
        tick();
        start    = 1'b0;
        done_ack = 1'b0;
        m_active = 1'b1;
        m_idx    = 0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_after_start", 32'(done), 32'd0);
        chk("ready_after_start", 32'(in_ready), 32'd1);
    endtask

    task automatic send_sample(input logic [DW-1:0] re, input logic [DW-1:0] im, input bit with_start);
        in_valid = 1'b1;
        in_real  = re;
        in_imag  = im;
        start    = with_start;
        chk("in_ready", 32'(in_ready), 32'(m_active));
        sb.push_back('{brev(m_idx), re, im, cyc + 1});
        m_idx++;
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
        if (m_idx == N) begin
            m_active = 1'b0;
            chk("done_on_last", 32'(done), 32'd1);
            chk("busy_on_last", 32'(busy), 32'd0);
        end else begin
            chk("busy_mid", 32'(busy), 32'd1);
            chk("done_mid", 32'(done), 32'd0);
        end
    endtask

    task automatic run_frame(input int mode, input int gap_at, input int gap_len, input int start_at);
        logic [DW-1:0] re, im;
        for (int k = 0; k < N; k++) begin
            if (k == gap_at) begin
                repeat (gap_len) begin
                    tick();
                    chk("busy_in_gap", 32'(busy), 32'd1);
                end
            end
            if (mode == 1 && $urandom_range(3) == 0) begin
                repeat ($urandom_range(1, 3)) tick();
            end
            re = (mode == 1) ? DW'($urandom) : DW'(k);
            im = (mode == 1) ? DW'($urandom) : DW'(-k);
            send_sample(re, im, k == start_at);
        end
    endtask

    task automatic drain();
        repeat (2) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic ack_frame();
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        chk("done_after_ack", 32'(done), 32'd0);
        chk("busy_after_ack", 32'(busy), 32'd0);
        chk("ready_after_ack", 32'(in_ready), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_real", 32'(wr_real), 32'd0);
        chk("rst_wr_imag", 32'(wr_imag), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Ramp frame back to back, then sticky done and acknowledge.
        do_start(1'b0);
        run_frame(0, -1, 0, -1);
        drain();
        repeat (3) tick();
        chk("done_sticky", 32'(done), 32'd1);
        ack_frame();

        // Random data with a 5-cycle stall after sample 3.
        do_start(1'b0);
        run_frame(1, 4, 5, -1);
        drain();

        // start and done_ack together restart; a start mid-frame is ignored.
        do_start(1'b1);
        run_frame(1, -1, 0, 4);
        drain();

        // Restart straight from DONE, then reset during the 5th sample's write.
        do_start(1'b0);
        for (int k = 0; k < 5; k++) begin
            send_sample(DW'($urandom), DW'($urandom), 1'b0);
        end
        reset = 1'b1;
        #1;
        chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        sb.delete();
        m_active  = 1'b0;
        last_addr = 0;
        last_re   = '0;
        last_im   = '0;
        tick();
        reset = 1'b0;
        tick();
        chk("idle_after_rst", 32'(busy), 32'd0);
        do_start(1'b0);
        run_frame(1, -1, 0, -1);
        drain();
        ack_frame();

`ifdef FFT_LOADER_PATTERN_GEN_EN
        begin
            int c;
            pat_mode = 1'b1;
            start    = 1'b1;
            tick();
            start    = 1'b0;
            pat_mode = 1'b0;
            c = cyc;
            for (int k = 0; k < N; k++) begin
                sb.push_back('{brev(k), (k < N / 2) ? AMP : DW'(-int'(AMP)), DW'(0), c + 1 + k});
            end
            for (int k = 0; k < N; k++) begin
                chk("pat_in_ready", 32'(in_ready), 32'd0);
                tick();
            end
            chk("pat_done", 32'(done), 32'd1);
            drain();
            ack_frame();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_sample_loader.md
Name: fft_sample_loader

Overview:
- Streams N complex samples from an upstream valid/ready source into the FFT working memory.
- Each write address is the bit-reversed sample index, which gives the decimation-in-time input ordering.
- Generalises the fixed 32-point loader with fixed constants: the point count and sample width are parameters, there is a start/done handshake with acknowledge, and an input stall is tolerated mid-frame.
- Sits between the ADC/sample front end and the butterfly engine's dual-port RAM.

Parameters:
- DATA_W, 16, bit width of each real and imaginary sample (two's complement).
- LOG2_N, 5, log2 of the FFT point count; N = 2**LOG2_N, legal range 2..12.
- PAT_AMP, 16'h03FF, positive amplitude of the internal test pattern (used only when PATTERN_GEN_EN is defined).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame load.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  loader accepts a sample this cycle.
- in_real  in  DATA_W  upstream real part.
- in_imag  in  DATA_W  upstream imaginary part.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  LOG2_N  bit-reversed RAM write address.
- wr_real  out  DATA_W  RAM write data, real part.
- wr_imag  out  DATA_W  RAM write data, imaginary part.
- busy  out  1  frame load in progress.
- done  out  1  frame complete; sticky until done_ack or start.
- done_ack  in  1  FFT engine has consumed the frame.
- pat_mode  in  1  selects the internal pattern source (port present only with PATTERN_GEN_EN).

Behaviour:
- States: IDLE, LOAD, DONE. Reset state is IDLE.
- Reset values: counter=0, wr_en=0, wr_addr=0, wr_real=0, wr_imag=0, busy=0, done=0.
- in_ready is combinational and equals (state==LOAD).
- A sample is accepted when in_valid && in_ready.
- IDLE -> LOAD on start. The counter clears to 0.
- LOAD, on accept:
  - wr_en, wr_addr=bitrev(counter), wr_real and wr_imag are registered, so they appear exactly one cycle after the accept.
  - counter increments.
  - If counter==N-1, go to DONE.
- LOAD with no accept: wr_en=0 and counter holds. Stalls of any length are legal.
- DONE:
  - done=1, busy=0.
  - done_ack -> IDLE, with done=0 the next cycle.
  - start -> LOAD, with done=0 and counter=0. start has priority over a simultaneous done_ack.
- start while in LOAD is ignored; it does not restart the frame.
- busy=1 exactly while in LOAD.
- The last write (index N-1 to address N-1) occurs in the same cycle that done first rises.
- wr_en is a one-cycle pulse per sample. When wr_en=0, wr_addr and the data outputs hold their last values.
- The counter is LOG2_N bits wide and never wraps inside a frame; the transition to DONE prevents overflow.
- Reset mid-frame: all state returns to reset values immediately (asynchronous), a pending write is dropped, and the partial frame is discarded.
- Data passes through unmodified; there is no scaling or saturation.

Optional Feature:
- Macro name: FFT_LOADER_PATTERN_GEN_EN.
- Defined:
  - The pat_mode port exists.
  - When pat_mode=1 in LOAD, in_ready=0 and the input is ignored.
  - One sample is produced every cycle: real=PAT_AMP for index < N/2, real=-PAT_AMP (0xFC01 at the default) for index >= N/2, imag=0. This is a square wave for bring-up.
  - pat_mode is sampled only on start and held for the whole frame.
- Undefined: the port and the pattern logic are absent, and behaviour is as with pat_mode=0.

Decomposition:
- Package fft_pkg holds:
  - the default DATA_W and LOG2_N constants;
  - the state enum typedef (IDLE, LOAD, DONE);
  - the PAT_AMP default.
- Sub-module fft_addr_bitrev (parameter ADDR_W) is purely combinational and reverses the bit order of an index. It is reused by the FFT output unloader.

Test Plan:
- LOG2_N=3, start, then 8 back-to-back samples real=k, imag=-k -> wr_addr sequence 0,4,2,6,1,5,3,7 with matching data, each one cycle after its accept; done rises on the cycle of the 8th write; busy falls on the same cycle.
- Deassert in_valid for 5 cycles after sample 3 -> no wr_en pulses during the gap, counter holds, the frame completes correctly after 8 total accepts.
- In DONE, done_ack -> done=0 and state IDLE. Separately, start and done_ack in the same cycle -> a new frame starts with counter=0.
- start pulsed mid-LOAD at sample 4 -> ignored; the frame finishes after sample 7 with addresses unaffected.
- Reset asserted at sample 5 -> wr_en, done and busy are 0 immediately. After release, a new start loads a full, clean frame beginning at address 0.
- With FFT_LOADER_PATTERN_GEN_EN defined, LOG2_N=5, pat_mode=1 -> 32 consecutive writes:
  - addresses 0,16,8,24,... in bit-reversed order;
  - real=0x03FF for indices 0-15 and 0xFC01 for indices 16-31, imag=0;
  - in_ready=0 throughout the frame.
